// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: round-robin shared 32-bit AND/OR/NOR/NOT engine with a tagged valid/ready response.
// Define LOGIC_ARB_STATS_EN to build the saturating per-requester grant counters.
module logic_unit_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int STAT_WIDTH = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ0_VALID,
  output logic                  REQ0_READY,
  input  logic [1:0]            REQ0_OP,
  input  logic [DATA_WIDTH-1:0] REQ0_A,
  input  logic [DATA_WIDTH-1:0] REQ0_B,
  input  logic                  REQ1_VALID,
  output logic                  REQ1_READY,
  input  logic [1:0]            REQ1_OP,
  input  logic [DATA_WIDTH-1:0] REQ1_A,
  input  logic [DATA_WIDTH-1:0] REQ1_B,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic                  RSP_ID,
  output logic [DATA_WIDTH-1:0] RSP_DATA,
  output logic [STAT_WIDTH-1:0] GRANT_CNT0,
  output logic [STAT_WIDTH-1:0] GRANT_CNT1
);
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;
  state_t                r_state, w_next;
  logic                  r_ptr, r_id, r_rsp_valid, r_rsp_id;
  logic [1:0]            r_op;
  logic [DATA_WIDTH-1:0] r_a, r_b, r_rsp_data;
  logic                  w_any, w_gnt_id, w_accept;
  logic [DATA_WIDTH-1:0] w_and, w_or, w_nor, w_inv, w_result;

  assign w_any      = REQ0_VALID | REQ1_VALID;
  assign w_gnt_id   = (REQ0_VALID && REQ1_VALID) ? r_ptr : REQ1_VALID;
  assign w_accept   = (r_state == IDLE) && !RST && w_any;
  assign REQ0_READY = w_accept && !w_gnt_id;
  assign REQ1_READY = w_accept && w_gnt_id;

  assign w_and    = r_a & r_b;
  assign w_or     = r_a | r_b;
  assign w_nor    = ~w_or;
  assign w_inv    = ~r_a;
  assign w_result = r_op[1] ? (r_op[0] ? w_inv : w_nor) : (r_op[0] ? w_or : w_and);

  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE) ? (w_any ? EXEC : IDLE) :
             (r_state == EXEC) ? RESP :
             (RSP_READY ? IDLE : RESP);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_ptr       <= 1'b0;
      r_id        <= 1'b0;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_id  <= w_gnt_id;
        r_op  <= w_gnt_id ? REQ1_OP : REQ0_OP;
        r_a   <= w_gnt_id ? REQ1_A : REQ0_A;
        r_b   <= w_gnt_id ? REQ1_B : REQ0_B;
        r_ptr <= ~w_gnt_id;
      end
      if (r_state == EXEC) begin
        r_rsp_valid <= 1'b1;
        r_rsp_id    <= r_id;
        r_rsp_data  <= w_result;
      end else if (r_state == RESP && RSP_READY) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign RSP_VALID = r_rsp_valid;
  assign RSP_ID    = r_rsp_id;
  assign RSP_DATA  = r_rsp_data;

`ifdef LOGIC_ARB_STATS_EN
  logic [STAT_WIDTH-1:0] r_cnt0, r_cnt1;
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (REQ0_READY && r_cnt0 != '1) r_cnt0 <= r_cnt0 + STAT_WIDTH'(1);
      if (REQ1_READY && r_cnt1 != '1) r_cnt1 <= r_cnt1 + STAT_WIDTH'(1);
    end
  end
  assign GRANT_CNT0 = r_cnt0;
  assign GRANT_CNT1 = r_cnt1;
`else
  assign GRANT_CNT0 = '0;
  assign GRANT_CNT1 = '0;
`endif
endmodule
